// File: rtl/grip_pkg.sv
// Shared definitions for the glove haptic/flex paths: buzz FSM state encoding,
// default PWM width and a small constant helper.
package grip_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } grip_state_e;

    localparam int GRIP_PWM_BITS = 4;

    function automatic int grip_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Restartable prescaler: pulses tick for one cycle every TICK_DIV clocks,
// counting from zero again whenever clear is asserted.
module tick_gen #(
    parameter int TICK_DIV = 27000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clear || (cnt_q == CNT_LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == CNT_LAST);

endmodule

// File: rtl/grip_haptic_driver.sv
// Vibration-motor driver: plays a single PWM buzz on grab and a multi-buzz
// pattern on slip, with slip able to restart a pattern already in progress.
module grip_haptic_driver
    import grip_pkg::*;
#(
    parameter int TICK_DIV    = 27000,
    parameter int BUZZ_TICKS  = 60,
    parameter int GAP_TICKS   = 40,
    parameter int SLIP_PULSES = 3,
    parameter int PWM_BITS    = GRIP_PWM_BITS
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                grab_evt,
    input  logic                slip_evt,
    input  logic [PWM_BITS-1:0] duty,
    output logic                motor_out,
    output logic                busy
);

    localparam int PW = $clog2(grip_max(BUZZ_TICKS, GAP_TICKS) + 1);
    localparam int QW = $clog2(SLIP_PULSES + 1);
    localparam logic [PW-1:0] BUZZ_LAST = PW'(BUZZ_TICKS - 1);
    localparam logic [PW-1:0] GAP_LAST  = PW'(GAP_TICKS - 1);

    grip_state_e         state_q, state_d;
    logic [QW-1:0]       pulses_q, pulses_d;
    logic [PW-1:0]       phase_q, phase_d;
    logic [PWM_BITS-1:0] pwm_q, pwm_d;
    logic [PWM_BITS-1:0] duty_q, duty_d;
    logic                motor_out_q, motor_out_d;

    logic tick;
    logic phase_clear;
    logic start_slip;
    logic start_grab;
    logic on_end;
    logic off_end;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .clear (phase_clear),
        .tick  (tick)
    );

    // A phase ends on the tick that completes its last tick period.
    assign on_end  = tick && (state_q == ST_ON)  && (phase_q == BUZZ_LAST);
    assign off_end = tick && (state_q == ST_OFF) && (phase_q == GAP_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            pulses_q    <= '0;
            phase_q     <= '0;
            pwm_q       <= '0;
            duty_q      <= '0;
            motor_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pulses_q    <= pulses_d;
            phase_q     <= phase_d;
            pwm_q       <= pwm_d;
            duty_q      <= duty_d;
            motor_out_q <= motor_out_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pulses_d    = pulses_q;
        phase_d     = phase_q;
        pwm_d       = pwm_q + PWM_BITS'(1);
        duty_d      = duty_q;
        phase_clear = 1'b0;
        start_slip  = 1'b0;
        start_grab  = 1'b0;

        if (tick && (state_q != ST_IDLE)) begin
            phase_d = phase_q + PW'(1);
        end

        unique case (state_q)
            ST_IDLE: begin
                pwm_d   = '0;
                phase_d = '0;
                if (slip_evt) begin
                    start_slip = 1'b1;
                end else if (grab_evt) begin
                    start_grab = 1'b1;
                end
            end
            ST_ON: begin
                if (slip_evt) begin
                    start_slip = 1'b1;
                end else if (on_end) begin
                    pulses_d = pulses_q - QW'(1);
                    if (pulses_q == QW'(1)) begin
                        // Last buzz done: no trailing gap, and a grab on this edge starts anew.
                        if (grab_evt) begin
                            start_grab = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                            phase_d = '0;
                            pwm_d   = '0;
                        end
                    end else begin
                        state_d     = ST_OFF;
                        phase_d     = '0;
                        pwm_d       = '0;
                        phase_clear = 1'b1;
                    end
                end
            end
            ST_OFF: begin
                if (slip_evt) begin
                    start_slip = 1'b1;
                end else if (off_end) begin
                    state_d     = ST_ON;
                    phase_d     = '0;
                    pwm_d       = '0;
                    phase_clear = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (start_slip || start_grab) begin
            state_d     = ST_ON;
            duty_d      = duty;
            pulses_d    = start_slip ? QW'(SLIP_PULSES) : QW'(1);
            phase_d     = '0;
            pwm_d       = '0;
            phase_clear = 1'b1;
        end
    end

    // Compare against next-cycle values so the drive lines up with the ON window.
    always_comb begin
        motor_out_d = (state_d == ST_ON) && (pwm_d < duty_d);
        busy        = (state_q != ST_IDLE);
        motor_out   = motor_out_q;
    end

endmodule

// File: tb/tb_grip_haptic_driver.sv
// Directed bench for grip_haptic_driver with small timing parameters so whole
// buzz patterns fit in a few dozen cycles.
module tb_grip_haptic_driver;

    localparam int TD = 4;
    localparam int BT = 3;
    localparam int GT = 2;
    localparam int SP = 3;
    localparam int PB = 4;
    localparam int ON_CYC  = BT * TD;
    localparam int GAP_CYC = GT * TD;

    logic          clk      = 1'b0;
    logic          reset    = 1'b1;
    logic          grab_evt = 1'b0;
    logic          slip_evt = 1'b0;
    logic [PB-1:0] duty     = '0;
    logic          motor_out;
    logic          busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    grip_haptic_driver #(
        .TICK_DIV    (TD),
        .BUZZ_TICKS  (BT),
        .GAP_TICKS   (GT),
        .SLIP_PULSES (SP),
        .PWM_BITS    (PB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .grab_evt  (grab_evt),
        .slip_evt  (slip_evt),
        .duty      (duty),
        .motor_out (motor_out),
        .busy      (busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b at t=%0t", tag, obs, expv, $time);
        end
    endtask

    // Walks an accepted pattern from its first busy cycle. inj >= 0 raises grab_evt
    // (and scrambles duty) at that cycle; chain raises grab_evt on the final ON cycle.
    task automatic expect_pattern(input string tag, input int pulses, input int dty,
                                  input int inj, input bit chain);
        int c;
        c = 0;
        $display("txn %s: pulses=%0d duty=%0d inj=%0d chain=%0d", tag, pulses, dty, inj, chain);
        for (int p = 0; p < pulses; p++) begin
            for (int i = 0; i < ON_CYC; i++) begin
                if (c == inj) begin
                    grab_evt = 1'b1;
                    duty     = 4'd15;
                end
                if (chain && (p == pulses - 1) && (i == ON_CYC - 1)) grab_evt = 1'b1;
                chk({tag, ".on_busy"}, busy, 1'b1);
                chk({tag, ".on_motor"}, motor_out, ((i % 16) < dty));
                step();
                grab_evt = 1'b0;
                c++;
            end
            if (p != pulses - 1) begin
                for (int g = 0; g < GAP_CYC; g++) begin
                    if (c == inj) begin
                        grab_evt = 1'b1;
                        duty     = 4'd15;
                    end
                    chk({tag, ".gap_busy"}, busy, 1'b1);
                    chk({tag, ".gap_motor"}, motor_out, 1'b0);
                    step();
                    grab_evt = 1'b0;
                    c++;
                end
            end
        end
        if (!chain) begin
            chk({tag, ".end_busy"}, busy, 1'b0);
            chk({tag, ".end_motor"}, motor_out, 1'b0);
        end
    endtask

    initial begin
        // 1. reset held, then idle with no events
        #2;
        chk("rst.busy", busy, 1'b0);
        chk("rst.motor", motor_out, 1'b0);
        step();
        step();
        reset = 1'b0;
        $display("txn idle: 100 cycles after reset release");
        for (int i = 0; i < 100; i++) begin
            step();
            chk("idle.busy", busy, 1'b0);
            chk("idle.motor", motor_out, 1'b0);
        end

        // 2. grab, full duty
        duty     = 4'd15;
        grab_evt = 1'b1;
        step();
        grab_evt = 1'b0;
        expect_pattern("grab15", 1, 15, -1, 1'b0);
        step();

        // 3. slip, duty 8
        duty     = 4'd8;
        slip_evt = 1'b1;
        step();
        slip_evt = 1'b0;
        expect_pattern("slip8", SP, 8, -1, 1'b0);
        step();

        // 4a. grab and slip together -> slip wins
        duty     = 4'd5;
        grab_evt = 1'b1;
        slip_evt = 1'b1;
        step();
        grab_evt = 1'b0;
        slip_evt = 1'b0;
        expect_pattern("both", SP, 5, -1, 1'b0);
        step();

        // 4b. slip at cycle 5 of a grab buzz restarts with re-latched duty
        duty     = 4'd15;
        grab_evt = 1'b1;
        step();
        grab_evt = 1'b0;
        $display("txn grab_then_slip: grab duty=15, slip at cycle 5 with duty=6");
        for (int i = 0; i < 4; i++) begin
            chk("restart.pre_busy", busy, 1'b1);
            chk("restart.pre_motor", motor_out, 1'b1);
            step();
        end
        duty     = 4'd6;
        slip_evt = 1'b1;
        chk("restart.c5_motor", motor_out, 1'b1);
        step();
        slip_evt = 1'b0;
        expect_pattern("restart", SP, 6, -1, 1'b0);
        step();

        // 4c. grab (with a duty change) in the middle of a slip gap changes nothing
        duty     = 4'd8;
        slip_evt = 1'b1;
        step();
        slip_evt = 1'b0;
        expect_pattern("slip_grab_gap", SP, 8, ON_CYC + 3, 1'b0);
        step();

        // grab during an ON window of a slip is ignored too
        duty     = 4'd3;
        slip_evt = 1'b1;
        step();
        slip_evt = 1'b0;
        expect_pattern("slip_grab_on", SP, 3, 2, 1'b0);
        step();

        // completion edge: grab on the final ON cycle starts a fresh buzz back to back
        duty     = 4'd4;
        grab_evt = 1'b1;
        step();
        grab_evt = 1'b0;
        expect_pattern("chain_a", 1, 4, -1, 1'b1);
        expect_pattern("chain_b", 1, 4, -1, 1'b0);
        step();

        // 5. duty 0: never drives, timing unchanged
        duty     = 4'd0;
        slip_evt = 1'b1;
        step();
        slip_evt = 1'b0;
        expect_pattern("duty0", SP, 0, -1, 1'b0);
        step();

        // 6. asynchronous reset mid-ON
        duty     = 4'd15;
        grab_evt = 1'b1;
        step();
        grab_evt = 1'b0;
        $display("txn reset_mid_on: reset between edges during ON");
        step();
        step();
        chk("rst_mid.pre_motor", motor_out, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk("rst_mid.busy", busy, 1'b0);
        chk("rst_mid.motor", motor_out, 1'b0);
        step();
        step();
        #2 reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("rst_mid.after_busy", busy, 1'b0);
            chk("rst_mid.after_motor", motor_out, 1'b0);
        end

        // normal operation resumes after reset
        duty     = 4'd10;
        grab_evt = 1'b1;
        step();
        grab_evt = 1'b0;
        expect_pattern("post_reset", 1, 10, -1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
